sector_buf_arbiter: RTL and testbench
=====================================

# sector_buf_arbiter

Shares the single read/write port of the 512-byte sector buffer between two byte-stream requesters (requester 0: SD card controller, requester 1: host-side disk controller, e.g. FDC/ACSI DMA). A requester holds the buffer for a whole burst. While it holds the buffer, the block generates the auto-incrementing byte address, muxes write data onto the buffer port and returns read data with a valid strobe. Arbitration is round-robin at burst granularity, with a one-cycle handover gap.

## Interface
- ADDR_W, 9, buffer address width; buffer depth is 2^ADDR_W bytes (512)
- clk  in  1  system clock; buffer port is clocked by the same clock
- rstn  in  1  asynchronous active-low reset
- req0, req1  in  1  burst request; held high for the whole burst
- gnt0, gnt1  out  1  registered grant; at most one high
- stb0, stb1  in  1  byte strobe; valid only while the matching gnt is high
- we0, we1  in  1  1 = write byte, 0 = read byte; qualified by stb
- wdata0, wdata1  in  8  write data; qualified by stb and we
- rdata  out  8  read data, shared by both requesters; equals ram_dout
- rvalid0, rvalid1  out  1  read data valid, one cycle after the read strobe
- done0, done1  out  1  one-cycle pulse after the last buffer byte is transferred
- cnt  out  ADDR_W+1  bytes transferred in the current burst
- ram_addr  out  ADDR_W  buffer address
- ram_din  out  8  buffer write data
- ram_we  out  1  buffer write enable
- ram_dout  in  8  buffer read data; registered, one-cycle latency

## Operation
- FSM states: IDLE, OWN0, OWN1, GAP. Reset state is IDLE.
- IDLE:
  - If only one req is high, go to that requester's OWN state.
  - If both are high, grant the requester that is not `last`. `last` resets to 1, so requester 0 wins the first tie.
  - On entering OWNn: gnt_n goes to 1, the address counter goes to 0, `full` goes to 0, and `last` is set to n.
- OWNn:
  - If req_n is low, go to GAP and clear gnt_n.
  - A strobe is accepted when stb_n=1, gnt_n=1 and full=0. Strobes from the non-granted requester are ignored.
  - ram_addr is the counter output (combinational from the register).
  - ram_we = accepted & we_n. ram_din = wdata_n of the owner.
  - On every accepted strobe the counter increments and cnt increments.
  - Accepted strobe at counter 2^ADDR_W−1: the counter wraps to 0, cnt reaches 2^ADDR_W, full goes to 1 and done_n pulses on the next cycle.
  - While full=1, strobes are ignored until req_n is released.
- GAP: lasts exactly one cycle, then IDLE. Both grants are low. Requests are evaluated again in IDLE.
- Reads: an accepted strobe with we=0 produces rvalid_n=1 one cycle later, and rdata holds the buffer byte at the strobed address. A read pending when req drops still delivers its rvalid.
- If stb arrives in the same cycle req drops, the strobe is still accepted; gnt is still high in that cycle.
- cnt holds its value through GAP and IDLE, and is cleared on the next grant.
- The buffer is never written except by an accepted strobe with we=1.

## Timing
- Reset values:
  - gnt0/1 = 0, rvalid0/1 = 0, done0/1 = 0
  - cnt = 0, ram_addr = 0, ram_we = 0, ram_din = 0
  - state = IDLE, last = 1, full = 0
- Grant latency: req high in cycle n (FSM in IDLE) gives gnt high in cycle n+1.
- Release: req low in cycle m gives gnt low in cycle m+1 (GAP). The earliest next grant is in cycle m+3, since m+2 is IDLE evaluation.
- Throughput: one byte per cycle while granted.
- Read latency: 1 cycle from strobe to rvalid/rdata.
- Write: takes effect at the strobe cycle's clock edge.
- done: pulses in cycle k+1 after the final strobe in cycle k.
- Reset asserted mid-burst: all outputs go immediately to their reset values, and any pending rvalid/done is dropped.

## Test plan
- Reset, then req0 high at cycle 0: gnt0=1 at cycle 1 and gnt1=0. Write 512 bytes with value = addr[7:0]. done0 pulses one cycle after the 512th strobe, cnt=512, and a 513th strobe leaves ram_we=0.
- req1 reads 4 bytes from address 0: rvalid1 one cycle after each strobe, rdata = 0x00, 0x01, 0x02, 0x03. Release req1: gnt1 low the next cycle.
- Tie fairness: req0 and req1 both high from IDLE after reset. gnt0 first; drop req0; gnt1 rises 2 cycles after gnt0 falls. On the next tie, gnt0 is granted because last=1.
- Non-owner isolation: while gnt0=1, stb1 with we1=1 and wdata1=0xAA. No ram_we, and a re-read of that address is unchanged.
- Release with in-flight read: stb0 read at addr 5 in the same cycle req0 drops. rvalid0=1 the next cycle with rdata=0x05, and gnt0=0.
- rstn pulled low mid-burst at cnt=100: gnt0, rvalid0, done0 and cnt go to 0 asynchronously. After release, a new req0 restarts at address 0.

Source files
------------

// File: rtl/sector_buf_arbiter.sv
// Burst-granular round-robin arbiter for the 512-byte sector buffer port.
// Requester 0 is the SD controller and requester 1 is the host disk controller.
module sector_buf_arbiter #(
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req0,
    input  logic              req1,
    output logic              gnt0,
    output logic              gnt1,
    input  logic              stb0,
    input  logic              stb1,
    input  logic              we0,
    input  logic              we1,
    input  logic [7:0]        wdata0,
    input  logic [7:0]        wdata1,
    output logic [7:0]        rdata,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic              done0,
    output logic              done1,
    output logic [ADDR_W:0]   cnt,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_din,
    output logic              ram_we,
    input  logic [7:0]        ram_dout
);

    localparam logic [ADDR_W-1:0] AddrMax = '1;

    typedef enum logic [1:0] {StIdle, StOwn0, StOwn1, StGap} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   cnt_q;
    logic              full_q;
    logic              last_q;
    logic              rvalid0_q, rvalid1_q;
    logic              done0_q, done1_q;

    logic acc0, acc1, acc, wrap, start;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // On a tie the requester that did not own the previous burst wins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (req0 && req1) begin
                    state_d = last_q ? StOwn0 : StOwn1;
                end else if (req0) begin
                    state_d = StOwn0;
                end else if (req1) begin
                    state_d = StOwn1;
                end
            end
            StOwn0:  if (!req0) state_d = StGap;
            StOwn1:  if (!req1) state_d = StGap;
            StGap:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state_q)
            StOwn0:  gnt0 = 1'b1;
            StOwn1:  gnt1 = 1'b1;
            default: ;
        endcase
    end

    assign acc0  = gnt0 & stb0 & ~full_q;
    assign acc1  = gnt1 & stb1 & ~full_q;
    assign acc   = acc0 | acc1;
    assign wrap  = acc && (addr_q == AddrMax);
    assign start = (state_q == StIdle) && (state_d != StIdle);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q    <= '0;
            cnt_q     <= '0;
            full_q    <= 1'b0;
            last_q    <= 1'b1;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
        end else begin
            rvalid0_q <= acc0 & ~we0;
            rvalid1_q <= acc1 & ~we1;
            done0_q   <= acc0 & wrap;
            done1_q   <= acc1 & wrap;
            if (start) begin
                addr_q <= '0;
                cnt_q  <= '0;
                full_q <= 1'b0;
                last_q <= (state_d == StOwn1);
            end else if (acc) begin
                addr_q <= addr_q + 1'b1;
                cnt_q  <= cnt_q + 1'b1;
                // Once the whole sector has moved, further strobes are dropped.
                if (wrap) begin
                    full_q <= 1'b1;
                end
            end
        end
    end

    assign ram_addr = addr_q;
    assign ram_we   = (acc0 & we0) | (acc1 & we1);
    assign ram_din  = gnt0 ? wdata0 : (gnt1 ? wdata1 : 8'h00);
    assign rdata    = ram_dout;
    assign rvalid0  = rvalid0_q;
    assign rvalid1  = rvalid1_q;
    assign done0    = done0_q;
    assign done1    = done1_q;
    assign cnt      = cnt_q;

endmodule

// File: tb/tb_sector_buf_arbiter.sv
// Scoreboard bench for sector_buf_arbiter: the driver pushes expected events,
// the negedge monitor pops and compares them against the DUT and a buffer model.
module tb_sector_buf_arbiter;

    localparam int ADDR_W = 9;
    localparam int DEPTH  = 1 << ADDR_W;

    localparam int SGnt0  = 0;
    localparam int SGnt1  = 1;
    localparam int SDone0 = 2;
    localparam int SDone1 = 3;
    localparam int SCnt   = 4;
    localparam int SAddr  = 5;
    localparam int SDin   = 6;

    logic              clk = 1'b0;
    logic              rstn;
    logic [1:0]        req, stb, we, gnt, rvalid, done;
    logic [7:0]        wdata [2];
    logic [7:0]        rdata, ram_din, ram_dout;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;

    logic [7:0] ram     [DEPTH];
    logic [7:0] ref_mem [DEPTH];

    typedef struct { int due; int who;  logic [7:0] data; } rd_t;
    typedef struct { int due; int addr; logic [7:0] data; } wr_t;
    typedef struct { int due; int sel;  int val; } ex_t;

    rd_t rq[$];
    wr_t wq[$];
    ex_t eq[$];

    int cyc       = 0;
    int checks    = 0;
    int errors    = 0;
    bit stim_done = 1'b0;
    int owner     = 0;
    int pos       = 0;
    int last_m    = 1;

    sector_buf_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .req0     (req[0]),
        .req1     (req[1]),
        .gnt0     (gnt[0]),
        .gnt1     (gnt[1]),
        .stb0     (stb[0]),
        .stb1     (stb[1]),
        .we0      (we[0]),
        .we1      (we[1]),
        .wdata0   (wdata[0]),
        .wdata1   (wdata[1]),
        .rdata    (rdata),
        .rvalid0  (rvalid[0]),
        .rvalid1  (rvalid[1]),
        .done0    (done[0]),
        .done1    (done[1]),
        .cnt      (cnt),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_we   (ram_we),
        .ram_dout (ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sector buffer: synchronous write, registered read.
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_din;
        ram_dout <= ram[ram_addr];
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
        $fatal(1);
    end

    function automatic int probe(int sel);
        case (sel)
            SGnt0:   return int'(gnt[0]);
            SGnt1:   return int'(gnt[1]);
            SDone0:  return int'(done[0]);
            SDone1:  return int'(done[1]);
            SCnt:    return int'(cnt);
            SAddr:   return int'(ram_addr);
            SDin:    return int'(ram_din);
            default: return -1;
        endcase
    endfunction

    function automatic string sig_name(int sel);
        case (sel)
            SGnt0:   return "gnt0";
            SGnt1:   return "gnt1";
            SDone0:  return "done0";
            SDone1:  return "done1";
            SCnt:    return "cnt";
            SAddr:   return "ram_addr";
            SDin:    return "ram_din";
            default: return "unknown";
        endcase
    endfunction

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        ex_t e;
        bit  exp_ev;
        if (!rstn) begin
            rq.delete();
            wq.delete();
        end
        for (int w = 0; w < 2; w++) begin
            exp_ev = (rq.size() > 0) && (rq[0].due == cyc) && (rq[0].who == w);
            check(w == 0 ? "rvalid0" : "rvalid1", int'(rvalid[w]), int'(exp_ev));
            if (exp_ev) begin
                check("rdata", int'(rdata), int'(rq[0].data));
                void'(rq.pop_front());
            end
        end
        exp_ev = (wq.size() > 0) && (wq[0].due == cyc);
        check("ram_we", int'(ram_we), int'(exp_ev));
        if (exp_ev) begin
            check("wr_addr", int'(ram_addr), wq[0].addr);
            check("wr_data", int'(ram_din), int'(wq[0].data));
            void'(wq.pop_front());
        end
        while (eq.size() > 0 && eq[0].due <= cyc) begin
            e = eq.pop_front();
            check(sig_name(e.sel), probe(e.sel), e.val);
        end
        if (stim_done) begin
            check("rd_queue_left", rq.size(), 0);
            check("wr_queue_left", wq.size(), 0);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void expect_sig(int sel, int val);
        eq.push_back('{cyc, sel, val});
    endfunction

    // FSM is idle this cycle with req already driven; predict the winner.
    task automatic arbitrate();
        int w;
        if (req == 2'b11) w = (last_m == 1) ? 0 : 1;
        else              w = req[0] ? 0 : 1;
        tick();
        expect_sig(SGnt0, int'(w == 0));
        expect_sig(SGnt1, int'(w == 1));
        expect_sig(SCnt, 0);
        expect_sig(SAddr, 0);
        owner  = w;
        last_m = w;
        pos    = 0;
    endtask

    task automatic xfer(bit do_stb, bit w, logic [7:0] d, bit drop, bit junk);
        int other;
        int a;
        bit hit;
        other = 1 - owner;
        hit   = 1'b0;
        stb[owner]   = do_stb;
        we[owner]    = w;
        wdata[owner] = d;
        if (junk) begin
            stb[other]   = 1'b1;
            we[other]    = 1'b1;
            wdata[other] = 8'hAA;
        end
        if (drop) req[owner] = 1'b0;
        expect_sig(SDin, int'(d));
        if (do_stb && pos < DEPTH) begin
            a = pos;
            expect_sig(SAddr, a);
            if (w) begin
                wq.push_back('{cyc, a, d});
                ref_mem[a] = d;
            end else begin
                rq.push_back('{cyc + 1, owner, ref_mem[a]});
            end
            pos++;
            hit = (pos == DEPTH);
        end
        tick();
        stb = 2'b00;
        we  = 2'b00;
        expect_sig(owner == 0 ? SDone0 : SDone1, int'(hit));
        expect_sig(SCnt, pos);
        if (drop) begin
            expect_sig(SGnt0, 0);
            expect_sig(SGnt1, 0);
            tick();
            expect_sig(SGnt0, 0);
            expect_sig(SGnt1, 0);
            expect_sig(SCnt, pos);
        end
    endtask

    task automatic do_reset();
        while (eq.size() > 0 && eq[eq.size() - 1].due == cyc) void'(eq.pop_back());
        rstn = 1'b0;
        req  = 2'b00;
        stb  = 2'b00;
        we   = 2'b00;
        expect_sig(SGnt0, 0);
        expect_sig(SGnt1, 0);
        expect_sig(SDone0, 0);
        expect_sig(SDone1, 0);
        expect_sig(SCnt, 0);
        expect_sig(SAddr, 0);
        expect_sig(SDin, 0);
        tick();
        tick();
        rstn   = 1'b1;
        last_m = 1;
        pos    = 0;
    endtask

    initial begin
        rstn     = 1'b1;
        req      = 2'b00;
        stb      = 2'b00;
        we       = 2'b00;
        wdata[0] = 8'h00;
        wdata[1] = 8'h00;
        tick();
        do_reset();

        // Full-sector write by requester 0, then one strobe past the end.
        req[0] = 1'b1;
        arbitrate();
        while (pos < DEPTH) begin
            if ($urandom_range(3) == 0) xfer(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0);
            xfer(1'b1, 1'b1, 8'(pos), 1'b0, 1'b0);
        end
        xfer(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
        xfer(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

        // Requester 1 reads back the first four bytes.
        req[1] = 1'b1;
        arbitrate();
        for (int i = 0; i < 4; i++) xfer(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
        xfer(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

        // Non-owner writes are ignored; last read issued together with release.
        req[0] = 1'b1;
        arbitrate();
        for (int i = 0; i < 3; i++) xfer(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
        xfer(1'b0, 1'b0, 8'($urandom), 1'b0, 1'b1);
        xfer(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
        xfer(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b1);
        xfer(1'b1, 1'b0, 8'($urandom), 1'b1, 1'b0);

        // Reset mid-burst with a read in flight, then restart from address 0.
        req[0] = 1'b1;
        arbitrate();
        for (int i = 0; i < 99; i++) xfer(1'b1, 1'b1, 8'($urandom), 1'b0, 1'($urandom_range(1)));
        xfer(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
        do_reset();
        req[0] = 1'b1;
        arbitrate();
        for (int i = 0; i < 3; i++) xfer(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0);
        xfer(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

        // Tie fairness from reset.
        do_reset();
        req = 2'b11;
        arbitrate();
        for (int i = 0; i < 3; i++) xfer(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0);
        xfer(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        arbitrate();
        for (int i = 0; i < 3; i++) xfer(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
        xfer(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        req = 2'b11;
        arbitrate();
        xfer(1'b1, 1'b0, 8'($urandom), 1'b1, 1'b0);
        arbitrate();
        xfer(1'b1, 1'b1, 8'($urandom), 1'b1, 1'b0);

        // Randomised bursts: mixed requesters, directions, gaps and intruders.
        for (int b = 0; b < 14; b++) begin
            int n;
            req = 2'($urandom_range(3, 1));
            arbitrate();
            n = ($urandom_range(3) == 0) ? DEPTH + 2 : $urandom_range(40, 1);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(3) == 0) begin
                    xfer(1'b0, 1'b1, 8'($urandom), 1'b0, 1'($urandom_range(1)));
                end
                xfer(1'b1, 1'($urandom_range(1)), 8'($urandom),
                     (i == n - 1) && ($urandom_range(1) == 1), 1'($urandom_range(1)));
            end
            if (req[owner]) xfer(1'b0, 1'b0, 8'($urandom), 1'b1, 1'b0);
        end

        req = 2'b00;
        tick();
        tick();
        stim_done = 1'b1;
        tick();
        tick();
    end

endmodule
